// File: rtl/seq_alu_core_pkg.sv
// Shared types for the sequential ALU core: opcodes, FSM state encoding and
// flag bit positions used by the core, its muldiv datapath and the bench.
package alu_pkg;

   typedef enum logic [3:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      AND = 4'd2,
      OR  = 4'd3,
      XOR = 4'd4,
      SHL = 4'd5,
      SHR = 4'd6,
      CMP = 4'd7,
      MUL = 4'd8,
      DIV = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int ZERO  = 0;
   localparam int NEG   = 1;
   localparam int CARRY = 2;
   localparam int OVF   = 3;
   localparam int DIV0  = 4;

endpackage

// File: rtl/seq_alu_core_if.sv
// Operand/result handshake bundle between the capture logic, the ALU core and
// the result consumer.
interface seq_alu_core_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   alu_pkg::op_e     op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] res_hi;
   logic [4:0]       flags;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, res_lo, res_hi, flags
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, res_lo, res_hi, flags
   );
endinterface

// File: rtl/seq_alu_core_muldiv.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one
// step per cycle for WIDTH cycles, then a one-cycle done pulse.
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    iter_q, iter_d;
   logic             busy_q, busy_d, done_q, done_d, isDiv_q, isDiv_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, operand_q, operand_d;
   logic [WIDTH:0]   mulSum, remShift, divTrial;

   // MUL keeps the multiplier in lo and shifts the partial product down;
   // DIV keeps the quotient bits in lo and the partial remainder in hi.
   always_comb begin
      iter_d    = iter_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      isDiv_d   = isDiv_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      operand_d = operand_q;
      mulSum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : '0);
      remShift  = {hi_q, lo_q[WIDTH-1]};
      divTrial  = remShift - {1'b0, operand_q};
      if (start) begin
         busy_d    = 1'b1;
         isDiv_d   = is_div;
         operand_d = is_div ? b : a;
         hi_d      = '0;
         lo_d      = is_div ? a : b;
         iter_d    = '0;
      end else if (busy_q) begin
         if (isDiv_q) begin
            if (!divTrial[WIDTH]) begin
               hi_d = divTrial[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = remShift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            {hi_d, lo_d} = {mulSum, lo_q[WIDTH-1:1]};
         end
         if (iter_q == CW'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            iter_d = '0;
         end else begin
            iter_d = iter_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iter_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         isDiv_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         operand_q <= '0;
      end else begin
         iter_q    <= iter_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         isDiv_q   <= isDiv_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         operand_q <= operand_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: valid/ready in, registered single-cycle ops plus an
// iterative muldiv unit, results and flags held until the consumer takes them.
module seq_alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   seq_alu_core_if.slave bus
);
   localparam int         SHW     = $clog2(WIDTH);
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_BUSY = BUSY;
   localparam logic [1:0] ST_DONE = DONE;

   logic [1:0]       state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] opA_q, opA_d, opB_q, opB_d;
   logic [WIDTH-1:0] resLo_q, resLo_d, resHi_q, resHi_d;
   logic [4:0]       flags_q, flags_d, newFlags;
   logic             accept, mdStart, mdBusy, mdDone, iterOp, divByZero;
   logic             sCarry, sOvf;
   logic [WIDTH-1:0] mdHi, mdLo, sLo, sHi, finLo, finHi, nzSrc;
   logic [WIDTH:0]   addSum, subDiff, shlExt, shrExt;
   logic [SHW-1:0]   shAmt;

   assign accept    = bus.in_valid && (state_q == ST_IDLE);
   assign mdStart   = accept && ((bus.op == MUL) || ((bus.op == DIV) && (bus.b != '0)));
   assign divByZero = (op_q == DIV) && (opB_q == '0);
   assign iterOp    = (op_q == MUL) || ((op_q == DIV) && !divByZero);

   // The muldiv unit loads straight from the bus on the accepting edge.
   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (mdStart),
      .is_div (bus.op == DIV),
      .a      (bus.a),
      .b      (bus.b),
      .busy   (mdBusy),
      .done   (mdDone),
      .hi     (mdHi),
      .lo     (mdLo)
   );

   always_comb begin
      addSum  = {1'b0, opA_q} + {1'b0, opB_q};
      subDiff = {1'b0, opA_q} - {1'b0, opB_q};
      shAmt   = opB_q[SHW-1:0];
      shlExt  = {1'b0, opA_q} << shAmt;
      shrExt  = {opA_q, 1'b0} >> shAmt;
      sLo     = '0;
      sHi     = '0;
      sCarry  = 1'b0;
      sOvf    = 1'b0;
      case (op_q)
         ADD: begin
            sLo    = addSum[WIDTH-1:0];
            sCarry = addSum[WIDTH];
            sOvf   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (addSum[WIDTH-1] != opA_q[WIDTH-1]);
         end
         SUB, CMP: begin
            sLo    = (op_q == SUB) ? subDiff[WIDTH-1:0] : '0;
            sCarry = subDiff[WIDTH];
            sOvf   = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) && (subDiff[WIDTH-1] != opA_q[WIDTH-1]);
         end
         AND: sLo = opA_q & opB_q;
         OR:  sLo = opA_q | opB_q;
         XOR: sLo = opA_q ^ opB_q;
         SHL: begin
            sLo    = shlExt[WIDTH-1:0];
            sCarry = shlExt[WIDTH];
         end
         SHR: begin
            sLo    = shrExt[WIDTH:1];
            sCarry = shrExt[0];
         end
         DIV: begin
            sLo = '1;
            sHi = opA_q;
         end
         default: ;
      endcase
      finLo = iterOp ? mdLo : sLo;
      finHi = iterOp ? mdHi : sHi;
      // CMP reports zero/neg of the difference it discards.
      nzSrc = (op_q == CMP) ? subDiff[WIDTH-1:0] : finLo;
      newFlags        = '0;
      newFlags[ZERO]  = (op_q == MUL) ? ({finHi, finLo} == '0) : (nzSrc == '0);
      newFlags[NEG]   = (op_q == MUL) ? finHi[WIDTH-1] : nzSrc[WIDTH-1];
      newFlags[CARRY] = sCarry;
      newFlags[OVF]   = sOvf;
      newFlags[DIV0]  = divByZero;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      resLo_d = resLo_q;
      resHi_d = resHi_q;
      flags_d = flags_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d    = bus.op;
               opA_d   = bus.a;
               opB_d   = bus.b;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!iterOp || (mdDone && !mdBusy)) begin
               resLo_d = finLo;
               resHi_d = finHi;
               flags_d = newFlags;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= ADD;
         opA_q   <= '0;
         opB_q   <= '0;
         resLo_q <= '0;
         resHi_q <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         resLo_q <= resLo_d;
         resHi_q <= resHi_d;
         flags_q <= flags_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.res_lo    = resLo_q;
   assign bus.res_hi    = resHi_q;
   assign bus.flags     = flags_q;
endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core at WIDTH=8: table of vectors through a
// scoreboard queue, plus back-pressure and mid-multiply reset sequences.
module tb_seq_alu_core;
   import alu_pkg::*;

   localparam int WIDTH = 8;

   typedef struct {
      op_e        op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] expLo;
      logic [7:0] expHi;
      logic [4:0] expFlags;
      int         expLat;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      logic [4:0] flags;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   testsRun = 0;
   int   testsFailed = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   seq_alu_core_if #(.WIDTH(WIDTH)) bus ();

   seq_alu_core #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic addVec(input op_e op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] lo, input logic [7:0] hi, input logic [4:0] fl,
                         input int lat, input string name);
      vec_t v;
      v.op = op; v.a = a; v.b = b;
      v.expLo = lo; v.expHi = hi; v.expFlags = fl;
      v.expLat = lat; v.name = name;
      vecs.push_back(v);
   endtask

   // Drives one op, pushes its expectation, and measures the accept-to-valid latency.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      int   lat;
      bit   seen;
      bit   readyLeak;
      bus.op       = v.op;
      bus.a        = v.a;
      bus.b        = v.b;
      bus.in_valid = 1'b1;
      checkVal({v.name, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      bus.op       = op_e'(4'($urandom_range(0, 15)));
      e.lo = v.expLo; e.hi = v.expHi; e.flags = v.expFlags; e.name = v.name;
      sb.push_back(e);
      lat       = 0;
      seen      = 1'b0;
      readyLeak = 1'b0;
      while (!seen && lat < 50) begin
         if (bus.in_ready) readyLeak = 1'b1;
         @(posedge clk); #1;
         lat++;
         if (bus.out_valid) seen = 1'b1;
      end
      if (bus.in_ready) readyLeak = 1'b1;
      checkVal({v.name, "_latency"}, 32'(lat), 32'(v.expLat));
      checkVal({v.name, "_in_ready_low"}, 32'(readyLeak), 32'd0);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checkVal("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      checkVal({e.name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      checkVal({e.name, "_res_lo"}, 32'(bus.res_lo), 32'(e.lo));
      checkVal({e.name, "_res_hi"}, 32'(bus.res_hi), 32'(e.hi));
      checkVal({e.name, "_flags"}, 32'(bus.flags), 32'(e.flags));
   endtask

   task automatic releaseOutput(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkVal({name, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
      checkVal({name, "_in_ready_rise"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      bit   held;
      bit   leaked;

      // flags = {div0, ovf, carry, neg, zero}
      addVec(ADD, 8'd200, 8'd100, 8'h2C, 8'h00, 5'b00100, 1, "add_carry");
      addVec(SUB, 8'd5,   8'd7,   8'hFE, 8'h00, 5'b00110, 1, "sub_borrow");
      addVec(CMP, 8'd9,   8'd9,   8'h00, 8'h00, 5'b00001, 1, "cmp_equal");
      addVec(CMP, 8'd3,   8'd5,   8'h00, 8'h00, 5'b00110, 1, "cmp_less");
      addVec(MUL, 8'hFF,  8'hFF,  8'h01, 8'hFE, 5'b00010, 9, "mul_max");
      addVec(DIV, 8'd100, 8'd7,   8'd14, 8'd2,  5'b00000, 9, "div_100_7");
      addVec(DIV, 8'h55,  8'h00,  8'hFF, 8'h55, 5'b10010, 1, "div_by_zero");
      addVec(ADD, 8'h7F,  8'h01,  8'h80, 8'h00, 5'b01010, 1, "add_ovf");
      addVec(ADD, 8'hFF,  8'h01,  8'h00, 8'h00, 5'b00101, 1, "add_wrap_zero");
      addVec(SUB, 8'h80,  8'h01,  8'h7F, 8'h00, 5'b01000, 1, "sub_ovf");
      addVec(AND, 8'hF0,  8'h3C,  8'h30, 8'h00, 5'b00000, 1, "and");
      addVec(OR,  8'hF0,  8'h0F,  8'hFF, 8'h00, 5'b00010, 1, "or");
      addVec(XOR, 8'hAA,  8'hAA,  8'h00, 8'h00, 5'b00001, 1, "xor_zero");
      addVec(SHL, 8'h81,  8'h01,  8'h02, 8'h00, 5'b00100, 1, "shl_1");
      addVec(SHL, 8'h81,  8'h0B,  8'h08, 8'h00, 5'b00000, 1, "shl_masked_3");
      addVec(SHR, 8'h81,  8'h00,  8'h81, 8'h00, 5'b00010, 1, "shr_0");
      addVec(SHR, 8'h81,  8'h01,  8'h40, 8'h00, 5'b00100, 1, "shr_1");
      addVec(MUL, 8'h00,  8'h37,  8'h00, 8'h00, 5'b00001, 9, "mul_zero");
      addVec(MUL, 8'h10,  8'h10,  8'h00, 8'h01, 5'b00000, 9, "mul_lo_zero");
      addVec(DIV, 8'h07,  8'h09,  8'h00, 8'h07, 5'b00001, 9, "div_small");
      addVec(DIV, 8'hFF,  8'h01,  8'hFF, 8'h00, 5'b00010, 9, "div_by_one");
      addVec(op_e'(4'd12), 8'h05, 8'h03, 8'h00, 8'h00, 5'b00001, 1, "nop_12");

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = ADD;
      bus.a         = '0;
      bus.b         = '0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkVal("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("reset_res_lo", 32'(bus.res_lo), 32'd0);
      checkVal("reset_res_hi", 32'(bus.res_hi), 32'd0);
      checkVal("reset_flags", 32'(bus.flags), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput();
         releaseOutput(vecs[i].name);
      end

      // Back-pressure: results must hold while a new offer is ignored.
      v.op = ADD; v.a = 8'd3; v.b = 8'd4; v.expLo = 8'd7; v.expHi = 8'd0;
      v.expFlags = 5'b00000; v.expLat = 1; v.name = "bp_add";
      applyStimulus(v);
      checkOutput();
      bus.in_valid = 1'b1;
      bus.op       = XOR;
      bus.a        = 8'h0F;
      bus.b        = 8'hF0;
      held = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.res_lo !== 8'd7 || bus.res_hi !== 8'd0 || bus.flags !== 5'd0 ||
             bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) held = 1'b0;
      end
      checkVal("bp_outputs_held", 32'(held), 32'd1);
      bus.in_valid = 1'b0;
      releaseOutput("bp");
      leaked = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.out_valid) leaked = 1'b1;
      end
      checkVal("bp_no_queued_op", 32'(leaked), 32'd0);
      v.op = XOR; v.a = 8'h0F; v.b = 8'hF0; v.expLo = 8'hFF; v.expHi = 8'h00;
      v.expFlags = 5'b00010; v.expLat = 1; v.name = "bp_next_xor";
      applyStimulus(v);
      checkOutput();
      releaseOutput("bp_next_xor");

      // Reset in the middle of a multiply must abort it silently.
      bus.op       = MUL;
      bus.a        = 8'hFF;
      bus.b        = 8'hFF;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkVal("rst_mid_mul_out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("rst_mid_mul_in_ready", 32'(bus.in_ready), 32'd1);
      checkVal("rst_mid_mul_res_lo", 32'(bus.res_lo), 32'd0);
      checkVal("rst_mid_mul_res_hi", 32'(bus.res_hi), 32'd0);
      checkVal("rst_mid_mul_flags", 32'(bus.flags), 32'd0);
      leaked = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.out_valid) leaked = 1'b1;
      end
      checkVal("rst_no_stale_result", 32'(leaked), 32'd0);
      v.op = ADD; v.a = 8'd1; v.b = 8'd1; v.expLo = 8'd2; v.expHi = 8'd0;
      v.expFlags = 5'b00000; v.expLat = 1; v.name = "post_rst_add";
      applyStimulus(v);
      checkOutput();
      releaseOutput("post_rst_add");

      checkVal("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
